// File: rtl/dcache_tag_pkg.sv
// Shared types and width helpers for the set-associative data-cache tag store.
// Each way holds one {valid, tag} word per set, with the valid bit as the MSB.
package dcache_tag_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  function automatic int entry_w(input int tag_width);
    return tag_width + 1;
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_tag_way_ram.sv
// One way of tag storage: a simple dual-port RAM with a synchronous read.
// A read and a write to the same address in one cycle return the old word.
module dcache_tag_way_ram #(
  parameter int AW = 9,
  parameter int DW = 21
) (
  input  logic          clk,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dcache_tag_array.sv
// N-way data-cache tag store with a one-cycle lookup pipeline, round-robin
// victim choice, and an invalidate sweep after reset and on flush.
module dcache_tag_array
  import dcache_tag_pkg::*;
#(
  parameter int SETS_LOG2 = 9,
  parameter int TAG_WIDTH = 20,
  parameter int WAYS      = 2,
  localparam int WAY_W    = way_w(WAYS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lk_valid,
  output logic                 lk_ready,
  input  logic [SETS_LOG2-1:0] lk_index,
  input  logic [TAG_WIDTH-1:0] lk_tag,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WAYS-1:0]      rsp_way,
  output logic [WAY_W-1:0]     rsp_victim,
  input  logic                 fill_en,
  input  logic [SETS_LOG2-1:0] fill_index,
  input  logic [WAY_W-1:0]     fill_way,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  input  logic                 inv_en,
  input  logic [SETS_LOG2-1:0] inv_index,
  input  logic [WAY_W-1:0]     inv_way,
  input  logic                 flush_req,
  output logic                 busy
);

  localparam int EW = entry_w(TAG_WIDTH);
  localparam logic [SETS_LOG2-1:0] LAST = '1;

  state_t               state_q, state_d;
  logic [SETS_LOG2-1:0] sweep_idx_q, sweep_idx_d;
  logic [WAY_W-1:0]     rr_q;
  logic                 lk_q_valid;
  logic [TAG_WIDTH-1:0] lk_q_tag;
  logic [WAYS-1:0]      vld;
  logic [WAYS-1:0]      match;
  logic [WAY_W-1:0]     victim;
  logic                 lk_acc;
  logic                 fill_ok;
  logic                 inv_ok;

  assign busy     = (state_q == SWEEP);
  assign lk_ready = !busy;
  assign lk_acc   = lk_valid && lk_ready;
  assign fill_ok  = fill_en && !busy;
  assign inv_ok   = inv_en && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    unique case (state_q)
      IDLE: if (flush_req) state_d = SWEEP;
      SWEEP: begin
        sweep_idx_d = sweep_idx_q + SETS_LOG2'(1);
        if (sweep_idx_q == LAST) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic                 sel_fill;
    logic                 sel_inv;
    logic                 we;
    logic [SETS_LOG2-1:0] wa;
    logic [EW-1:0]        wd;
    logic [EW-1:0]        rd;

    assign sel_fill = fill_ok && (fill_way == WAY_W'(w));
    // Fill beats an invalidate aimed at the same way.
    assign sel_inv  = inv_ok && (inv_way == WAY_W'(w)) && !sel_fill;

    always_comb begin
      we = 1'b0;
      wa = fill_index;
      wd = '0;
      unique case (1'b1)
        busy: begin
          we = 1'b1;
          wa = sweep_idx_q;
        end
        sel_fill: begin
          we = 1'b1;
          wd = {1'b1, fill_tag};
        end
        sel_inv: begin
          we = 1'b1;
          wa = inv_index;
        end
        default: ;
      endcase
    end

    dcache_tag_way_ram #(
      .AW(SETS_LOG2),
      .DW(EW)
    ) u_ram (
      .clk    (clk),
      .rd_en  (lk_acc),
      .rd_addr(lk_index),
      .rd_data(rd),
      .we     (we),
      .wr_addr(wa),
      .wr_data(wd)
    );

    assign vld[w]   = rd[EW-1];
    assign match[w] = rd[EW-1] && (rd[TAG_WIDTH-1:0] == lk_q_tag);
  end

  always_comb begin
    victim = rr_q;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!vld[w]) victim = WAY_W'(w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (fill_ok) begin
      rr_q <= (rr_q == WAY_W'(WAYS - 1)) ? '0 : rr_q + WAY_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_q_valid <= 1'b0;
      lk_q_tag   <= '0;
      rsp_valid  <= 1'b0;
      rsp_hit    <= 1'b0;
      rsp_way    <= '0;
      rsp_victim <= '0;
    end else begin
      lk_q_valid <= lk_acc;
      if (lk_acc) lk_q_tag <= lk_tag;
      rsp_valid <= lk_q_valid;
      if (lk_q_valid) begin
        rsp_hit    <= |match;
        rsp_way    <= match;
        rsp_victim <= victim;
      end
    end
  end

  a_one_hit : assert property (
    @(posedge clk) disable iff (!rst_n)
    lk_q_valid |-> $onehot0(match)
  );

endmodule

// File: tb/tb_dcache_tag_array.sv
// Directed bench for dcache_tag_array with a response scoreboard.
// Lookups push expected results; a monitor pops them on rsp_valid.
module tb_dcache_tag_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lk_valid = 1'b0;
  logic        lk_ready;
  logic [8:0]  lk_index = '0;
  logic [19:0] lk_tag = '0;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic [0:0]  rsp_victim;
  logic        fill_en = 1'b0;
  logic [8:0]  fill_index = '0;
  logic [0:0]  fill_way = '0;
  logic [19:0] fill_tag = '0;
  logic        inv_en = 1'b0;
  logic [8:0]  inv_index = '0;
  logic [0:0]  inv_way = '0;
  logic        flush_req = 1'b0;
  logic        busy;

  typedef struct {
    string      name;
    logic       hit;
    logic [1:0] way;
    logic       victim;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   rr_m = 0;

  always #5 clk = ~clk;

  dcache_tag_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_valid  (lk_valid),
    .lk_ready  (lk_ready),
    .lk_index  (lk_index),
    .lk_tag    (lk_tag),
    .rsp_valid (rsp_valid),
    .rsp_hit   (rsp_hit),
    .rsp_way   (rsp_way),
    .rsp_victim(rsp_victim),
    .fill_en   (fill_en),
    .fill_index(fill_index),
    .fill_way  (fill_way),
    .fill_tag  (fill_tag),
    .inv_en    (inv_en),
    .inv_index (inv_index),
    .inv_way   (inv_way),
    .flush_req (flush_req),
    .busy      (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert ({rsp_hit, rsp_way, rsp_victim} === {e.hit, e.way, e.victim})
        else begin
          errors++;
          $error("FAIL %s observed=%b/%b/%b expected=%b/%b/%b", e.name,
                 rsp_hit, rsp_way, rsp_victim, e.hit, e.way, e.victim);
        end
      end
    end
  end

  task automatic push(input string n, input logic h, input logic [1:0] w,
                      input int v);
    exp_t e;
    e.name = n;
    e.hit = h;
    e.way = w;
    e.victim = v[0];
    sb.push_back(e);
  endtask

  task automatic lookup(input string n, input logic [8:0] idx,
                        input logic [19:0] tag, input logic h,
                        input logic [1:0] w, input int v);
    @(negedge clk);
    chk({n, "_ready"}, lk_ready, 1);
    lk_valid = 1'b1;
    lk_index = idx;
    lk_tag = tag;
    push(n, h, w, v);
    @(negedge clk);
    lk_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic fill(input logic [8:0] idx, input logic w,
                      input logic [19:0] tag);
    @(negedge clk);
    fill_en = 1'b1;
    fill_index = idx;
    fill_way = w;
    fill_tag = tag;
    rr_m = (rr_m + 1) % 2;
    @(negedge clk);
    fill_en = 1'b0;
  endtask

  task automatic sweep_count(input string n, input int drop_at);
    int cnt = 0;
    int bad = 0;
    while (busy && cnt < 2000) begin
      if (lk_ready) bad++;
      cnt++;
      if (cnt == drop_at) flush_req = 1'b0;
      @(negedge clk);
    end
    flush_req = 1'b0;
    chk({n, "_len"}, cnt, 512);
    chk({n, "_ready_low"}, bad, 0);
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_busy"}, busy, 1);
    chk({n, "_ready"}, lk_ready, 0);
    chk({n, "_rsp_valid"}, rsp_valid, 0);
    chk({n, "_rsp_hit"}, rsp_hit, 0);
    chk({n, "_rsp_way"}, rsp_way, 0);
    chk({n, "_rsp_victim"}, rsp_victim, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    sweep_count("init_sweep", 0);

    lookup("cold_miss", 9'd5, 20'h12345, 1'b0, 2'b00, 0);

    fill(9'd5, 1'b1, 20'h12345);
    lookup("fill_hit", 9'd5, 20'h12345, 1'b1, 2'b10, 0);

    fill(9'd7, 1'b0, 20'h0000A);
    fill(9'd7, 1'b1, 20'h0000B);
    lookup("rr_a", 9'd7, 20'h0000C, 1'b0, 2'b00, rr_m);
    fill(9'd20, 1'b0, 20'h0000D);
    lookup("rr_b", 9'd7, 20'h0000C, 1'b0, 2'b00, rr_m);
    fill(9'd20, 1'b1, 20'h0000E);
    lookup("rr_c", 9'd7, 20'h0000C, 1'b0, 2'b00, rr_m);
    lookup("hit_b", 9'd7, 20'h0000B, 1'b1, 2'b10, rr_m);
    lookup("hit_d", 9'd20, 20'h0000D, 1'b1, 2'b01, rr_m);

    @(negedge clk);
    lk_valid = 1'b1;
    lk_index = 9'd9;
    lk_tag = 20'h1;
    fill_en = 1'b1;
    fill_index = 9'd9;
    fill_way = 1'b0;
    fill_tag = 20'h1;
    rr_m = (rr_m + 1) % 2;
    push("read_first", 1'b0, 2'b00, 0);
    @(negedge clk);
    lk_valid = 1'b0;
    fill_en = 1'b0;
    lookup("after_fill", 9'd9, 20'h1, 1'b1, 2'b01, 1);

    @(negedge clk);
    fill_en = 1'b1;
    fill_index = 9'd3;
    fill_way = 1'b0;
    fill_tag = 20'h55;
    inv_en = 1'b1;
    inv_index = 9'd3;
    inv_way = 1'b0;
    rr_m = (rr_m + 1) % 2;
    @(negedge clk);
    fill_en = 1'b0;
    inv_en = 1'b0;
    lookup("fill_wins", 9'd3, 20'h55, 1'b1, 2'b01, 1);
    @(negedge clk);
    inv_en = 1'b1;
    @(negedge clk);
    inv_en = 1'b0;
    lookup("inv_miss", 9'd3, 20'h55, 1'b0, 2'b00, 0);

    @(negedge clk);
    fill_en = 1'b1;
    fill_index = 9'd3;
    fill_way = 1'b1;
    fill_tag = 20'h66;
    inv_en = 1'b1;
    inv_index = 9'd9;
    inv_way = 1'b0;
    rr_m = (rr_m + 1) % 2;
    @(negedge clk);
    fill_en = 1'b0;
    inv_en = 1'b0;
    lookup("both_fill", 9'd3, 20'h66, 1'b1, 2'b10, 0);
    lookup("both_inv", 9'd9, 20'h1, 1'b0, 2'b00, 0);

    @(negedge clk);
    lk_valid = 1'b1;
    lk_index = 9'd5;
    lk_tag = 20'h12345;
    flush_req = 1'b1;
    push("flush_lookup", 1'b1, 2'b10, 0);
    @(negedge clk);
    lk_valid = 1'b0;
    sweep_count("flush_sweep", 100);
    lookup("post_flush_5", 9'd5, 20'h12345, 1'b0, 2'b00, 0);
    lookup("post_flush_7", 9'd7, 20'h0000A, 1'b0, 2'b00, 0);
    lookup("post_flush_20", 9'd20, 20'h0000D, 1'b0, 2'b00, 0);
    fill(9'd30, 1'b0, 20'h30);

    @(negedge clk);
    flush_req = 1'b1;
    @(negedge clk);
    flush_req = 1'b0;
    chk("flush2_busy", busy, 1);
    repeat (99) @(negedge clk);
    rst_n = 1'b0;
    rr_m = 0;
    #2 chk_reset_outputs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    sweep_count("restart_sweep", 0);
    lookup("rst_cleared", 9'd30, 20'h30, 1'b0, 2'b00, 0);
    fill(9'd7, 1'b0, 20'h0000A);
    fill(9'd7, 1'b1, 20'h0000B);
    lookup("rr_after_rst", 9'd7, 20'h0000C, 1'b0, 2'b00, rr_m);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
